// File: rtl/trace_uart_tx_pkg.sv
// Shared definitions for the trace UART transmitter: frame layout, sync byte default,
// serialiser state encoding and the overflow counter helper.
package trace_uart_tx_pkg;

    localparam int unsigned FRAME_BYTES       = 5;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous snapshot FIFO; an extra pointer bit tells full from empty.
// A push while full is accepted only when a pop frees a slot on the same edge.
module trace_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en, rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_en    = push && (!full || pop);
        rd_en    = pop && !empty;
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/trace_uart_tx.sv
// Captures {pc, A, B, ALU} on every PC change, queues snapshots and sends each one as
// a 5-byte 8N1 frame (SYNC, pc, A, B, ALU) on a registered, idle-high tx pin.
module trace_uart_tx
    import trace_uart_tx_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                DEPTH        = 4,
    parameter int                CLKS_PER_BIT = 4,
    parameter logic [DATA_W-1:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trace_en,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] rega_in,
    input  logic [DATA_W-1:0] regb_in,
    input  logic [DATA_W-1:0] alu_in,
    output logic              tx,
    output logic              busy,
    output logic [7:0]        overflow_cnt
);

    localparam int FW     = 4 * DATA_W;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int BYTE_W = $clog2(FRAME_BYTES);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              tx_q, tx_d;
    logic              pc_valid_q, pc_valid_d;
    logic [7:0]        ovf_q, ovf_d;
    logic [DATA_W-1:0] pc_last_q, pc_last_d;
    logic [FW-1:0]     frame_q, frame_d;

    logic              capture, pop, baud_last;
    logic              fifo_full, fifo_empty;
    logic [FW-1:0]     fifo_rdata;
    logic [DATA_W-1:0] cur_byte;

    trace_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (capture),
        .pop   (pop),
        .wdata ({pc_in, rega_in, regb_in, alu_in}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // pc_last tracks every capture, including those the FIFO has to drop
    always_comb begin
        capture    = trace_en && (!pc_valid_q || (pc_in != pc_last_q));
        pop        = (state_q == ST_IDLE) && !fifo_empty;
        pc_last_d  = capture ? pc_in : pc_last_q;
        pc_valid_d = pc_valid_q || capture;
        ovf_d      = (capture && fifo_full && !pop) ? sat_inc8(ovf_q) : ovf_q;
        frame_d    = pop ? fifo_rdata : frame_q;
    end

    always_comb begin
        case (byte_q)
            BYTE_W'(1): cur_byte = frame_q[FW-1 -: DATA_W];
            BYTE_W'(2): cur_byte = frame_q[3*DATA_W-1 -: DATA_W];
            BYTE_W'(3): cur_byte = frame_q[2*DATA_W-1 -: DATA_W];
            BYTE_W'(4): cur_byte = frame_q[DATA_W-1:0];
            default:    cur_byte = SYNC_BYTE;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        tx_d      = 1'b1;
        baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    state_d = ST_START;
                    byte_d  = '0;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                tx_d = cur_byte[bit_q];
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (byte_q == BYTE_W'(FRAME_BYTES - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        byte_d  = byte_q + BYTE_W'(1);
                        state_d = ST_START;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            tx_q       <= 1'b1;
            pc_valid_q <= 1'b0;
            ovf_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            tx_q       <= tx_d;
            pc_valid_q <= pc_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    // Payload registers carry no reset; pc_valid and the FSM qualify their use
    always_ff @(posedge clk) begin
        pc_last_q <= pc_last_d;
        frame_q   <= frame_d;
    end

    assign tx           = tx_q;
    assign busy         = (state_q != ST_IDLE) || !fifo_empty;
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_trace_uart_tx.sv
// Bench for trace_uart_tx: transaction-level model of capture/queue/send timing plus an
// independent 8N1 receiver that decodes the tx pin.
module tb_trace_uart_tx;

    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME_CYC = 50 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       trace_en;
    logic [7:0] pc_in, rega_in, regb_in, alu_in;
    logic       tx, busy;
    logic [7:0] overflow_cnt;

    int vectors = 0;
    int errors  = 0;

    trace_uart_tx #(
        .DATA_W       (8),
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .trace_en     (trace_en),
        .pc_in        (pc_in),
        .rega_in      (rega_in),
        .regb_in      (regb_in),
        .alu_in       (alu_in),
        .tx           (tx),
        .busy         (busy),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: queue of snapshots, transmitter free again FRAME_CYC+1 edges after a pop
    logic [31:0] m_q[$];
    logic [7:0]  exp_bytes[$];
    int          cyc = 0;
    int          free_at = 0;
    logic        m_pc_valid = 1'b0;
    logic [7:0]  m_pc_last = 8'h00;
    logic [7:0]  m_ovf = 8'h00;
    logic [31:0] m_head;
    bit          m_pop, m_cap;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_q.delete();
            free_at    = 0;
            m_pc_valid = 1'b0;
            m_ovf      = 8'h00;
        end else begin
            m_pop = (cyc >= free_at) && (m_q.size() > 0);
            m_cap = trace_en && (!m_pc_valid || (pc_in != m_pc_last));
            if (m_pop) begin
                m_head = m_q.pop_front();
                exp_bytes.push_back(8'hA5);
                exp_bytes.push_back(m_head[31:24]);
                exp_bytes.push_back(m_head[23:16]);
                exp_bytes.push_back(m_head[15:8]);
                exp_bytes.push_back(m_head[7:0]);
                free_at = cyc + FRAME_CYC + 1;
            end
            if (m_cap) begin
                m_pc_last  = pc_in;
                m_pc_valid = 1'b1;
                if (m_q.size() < DEPTH) m_q.push_back({pc_in, rega_in, regb_in, alu_in});
                else if (m_ovf != 8'hFF) m_ovf = m_ovf + 8'd1;
            end
        end
    end

    // 8N1 receiver sampling on the falling edge
    logic [7:0] rx_bytes[$];
    int         rx_starts[$];
    int         nedge = 0;
    bit         rx_active = 1'b0;
    int         rx_t, rx_start_cyc, rx_k;
    int         rx_framing_err = 0;
    logic [7:0] rx_sh;

    always @(negedge clk) begin
        nedge++;
        if (reset) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active    = 1'b1;
                rx_t         = 0;
                rx_start_cyc = nedge;
                rx_sh        = 8'h00;
            end
        end else begin
            rx_t++;
            if (rx_t % CPB == 0) begin
                rx_k = rx_t / CPB;
                if (rx_k <= 8) begin
                    rx_sh[rx_k-1] = tx;
                end else begin
                    if (tx !== 1'b1) rx_framing_err++;
                    rx_bytes.push_back(rx_sh);
                    rx_starts.push_back(rx_start_cyc);
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || rx_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles (busy=%0b rx_active=%0b), required idle", n, busy, rx_active);
        end
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic clear_streams();
        exp_bytes.delete();
        rx_bytes.delete();
        rx_starts.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; trace_en = 1'b0;
        pc_in = 8'h00; rega_in = 8'h00; regb_in = 8'h00; alu_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", tx); end
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        vectors++;
        if (overflow_cnt !== 8'h00) begin errors++; $display("FAIL reset_ovf: got %h, required 00", overflow_cnt); end
    endtask

    task automatic test_single_frame();
        logic [7:0] want[5];
        want = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h46};
        trace_en = 1'b1; pc_in = 8'h00; rega_in = 8'h12; regb_in = 8'h34; alu_in = 8'h46;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (tx !== 1'b1) begin errors++; $display("FAIL latency_edge0: tx %b, required 1", tx); end
        @(posedge clk); #1;
        vectors++;
        if (tx !== 1'b1) begin errors++; $display("FAIL latency_edge1: tx %b, required 1", tx); end
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_edge1: got %b, required 1", busy); end
        @(posedge clk); #1;
        vectors++;
        if (tx !== 1'b0) begin errors++; $display("FAIL latency_edge2: tx %b, required 0", tx); end
        wait_idle(3 * FRAME_CYC);
        vectors++;
        if (rx_bytes.size() != 5) begin
            errors++; $display("FAIL single_frame_len: got %0d bytes, required 5", rx_bytes.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (rx_bytes[i] !== want[i] || exp_bytes[i] !== want[i]) begin
                    errors++;
                    $display("FAIL single_frame_byte%0d: rx %h model %h, required %h", i, rx_bytes[i], exp_bytes[i], want[i]);
                end
            end
        end
        clear_streams();
    endtask

    task automatic test_pc_repeat();
        @(posedge clk); #1;
        pc_in = 8'h01; rega_in = 8'($urandom); regb_in = 8'($urandom); alu_in = 8'($urandom);
        repeat (20) @(posedge clk);
        #1;
        wait_idle(3 * FRAME_CYC);
        vectors++;
        if (rx_bytes.size() != 5 || exp_bytes.size() != 5) begin
            errors++; $display("FAIL pc_repeat_len: rx %0d model %0d bytes, required 5", rx_bytes.size(), exp_bytes.size());
        end else begin
            vectors++;
            if (rx_bytes[1] !== 8'h01) begin errors++; $display("FAIL pc_repeat_pc: got %h, required 01", rx_bytes[1]); end
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (rx_bytes[i] !== exp_bytes[i]) begin
                    errors++; $display("FAIL pc_repeat_byte%0d: got %h, required %h", i, rx_bytes[i], exp_bytes[i]);
                end
            end
        end
        clear_streams();
    endtask

    task automatic test_overflow();
        logic [7:0] cap_pcs[$];
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            pc_in   = pc_in + 8'(1 + $urandom_range(0, 254));
            rega_in = 8'($urandom); regb_in = 8'($urandom); alu_in = 8'($urandom);
            cap_pcs.push_back(pc_in);
        end
        wait_idle(8 * FRAME_CYC);
        vectors++;
        if (overflow_cnt !== 8'd3 || overflow_cnt !== m_ovf) begin
            errors++; $display("FAIL overflow_cnt: got %0d model %0d, required 3", overflow_cnt, m_ovf);
        end
        vectors++;
        if (rx_bytes.size() != 25 || exp_bytes.size() != 25) begin
            errors++; $display("FAIL overflow_len: rx %0d model %0d bytes, required 25", rx_bytes.size(), exp_bytes.size());
        end else begin
            for (int f = 0; f < 5; f++) begin
                vectors++;
                if (rx_bytes[5*f+1] !== cap_pcs[f]) begin
                    errors++; $display("FAIL overflow_order%0d: pc %h, required %h", f, rx_bytes[5*f+1], cap_pcs[f]);
                end
            end
            for (int i = 0; i < 25; i++) begin
                vectors++;
                if (rx_bytes[i] !== exp_bytes[i]) begin
                    errors++; $display("FAIL overflow_byte%0d: got %h, required %h", i, rx_bytes[i], exp_bytes[i]);
                end
            end
        end
        clear_streams();
    endtask

    task automatic test_trace_disable();
        logic [7:0] ovf_before;
        int         bad;
        ovf_before = overflow_cnt;
        bad = 0;
        trace_en = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
            pc_in = pc_in + 8'(1 + $urandom_range(0, 254));
        end
        vectors++;
        if (bad != 0) begin errors++; $display("FAIL disable_idle: %0d cycles with tx!=1 or busy!=0, required 0", bad); end
        vectors++;
        if (overflow_cnt !== ovf_before) begin
            errors++; $display("FAIL disable_ovf: got %0d, required %0d", overflow_cnt, ovf_before);
        end
        vectors++;
        if (rx_bytes.size() != 0) begin errors++; $display("FAIL disable_frames: got %0d bytes, required 0", rx_bytes.size()); end
        clear_streams();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] want[5];
        int         bad;
        @(posedge clk); #1;
        trace_en = 1'b1;
        pc_in    = m_pc_last + 8'd1;
        rega_in  = 8'($urandom) & 8'hEF;
        regb_in  = 8'($urandom); alu_in = 8'($urandom);
        repeat (3 + 25 * CPB) @(posedge clk);
        #1;
        vectors++;
        if (tx !== 1'b0) begin errors++; $display("FAIL midframe_bit: tx %b, required 0 (A bit4)", tx); end
        vectors++;
        if (rx_bytes.size() != 2 || rx_bytes[0] !== 8'hA5 || rx_bytes[1] !== pc_in) begin
            errors++; $display("FAIL midframe_prefix: got %0d bytes, required A5 %h", rx_bytes.size(), pc_in);
        end
        trace_en = 1'b0;
        reset = 1'b1;
        #1;
        vectors++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_async_tx: got %b, required 1", tx); end
        clear_streams();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || overflow_cnt !== 8'h00) begin
            errors++; $display("FAIL post_reset: busy %b ovf %h, required 0 00", busy, overflow_cnt);
        end
        bad = 0;
        for (int i = 0; i < 3 * FRAME_CYC; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0 || rx_bytes.size() != 0) begin
            errors++; $display("FAIL residual_frame: %0d active cycles, %0d bytes, required 0 0", bad, rx_bytes.size());
        end
        rega_in = 8'($urandom); regb_in = 8'($urandom); alu_in = 8'($urandom);
        want = '{8'hA5, pc_in, rega_in, regb_in, alu_in};
        trace_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wait_idle(3 * FRAME_CYC);
        vectors++;
        if (rx_bytes.size() != 5 || exp_bytes.size() != 5) begin
            errors++; $display("FAIL after_reset_len: rx %0d model %0d bytes, required 5", rx_bytes.size(), exp_bytes.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (rx_bytes[i] !== want[i] || exp_bytes[i] !== want[i]) begin
                    errors++; $display("FAIL after_reset_byte%0d: rx %h model %h, required %h", i, rx_bytes[i], exp_bytes[i], want[i]);
                end
            end
        end
        clear_streams();
    endtask

    task automatic test_back_to_back();
        int gap, bad_inner;
        for (int i = 0; i < 330; i++) begin
            @(posedge clk); #1;
            pc_in   = pc_in + 8'(1 + $urandom_range(0, 254));
            rega_in = 8'($urandom); regb_in = 8'($urandom); alu_in = 8'($urandom);
        end
        vectors++;
        if (overflow_cnt !== 8'hFF || m_ovf !== 8'hFF) begin
            errors++; $display("FAIL ovf_saturate: got %h model %h, required FF", overflow_cnt, m_ovf);
        end
        wait_idle(10 * FRAME_CYC);
        vectors++;
        if (overflow_cnt !== 8'hFF) begin errors++; $display("FAIL ovf_hold: got %h, required FF", overflow_cnt); end
        vectors++;
        if (rx_bytes.size() != exp_bytes.size() || rx_bytes.size() < 15) begin
            errors++; $display("FAIL b2b_len: rx %0d model %0d bytes, required equal and >=15", rx_bytes.size(), exp_bytes.size());
        end else begin
            for (int i = 0; i < rx_bytes.size(); i++) begin
                vectors++;
                if (rx_bytes[i] !== exp_bytes[i]) begin
                    errors++; $display("FAIL b2b_byte%0d: got %h, required %h", i, rx_bytes[i], exp_bytes[i]);
                end
            end
            bad_inner = 0;
            for (int i = 1; i < rx_starts.size(); i++) begin
                gap = rx_starts[i] - rx_starts[i-1] - 10 * CPB;
                if (i % 5 == 0) begin
                    vectors++;
                    if (gap != 1) begin errors++; $display("FAIL frame_gap%0d: got %0d clk, required 1", i / 5, gap); end
                end else if (gap != 0) begin
                    bad_inner++;
                end
            end
            vectors++;
            if (bad_inner != 0) begin errors++; $display("FAIL byte_gap: %0d non-zero gaps, required 0", bad_inner); end
        end
        vectors++;
        if (rx_framing_err != 0) begin errors++; $display("FAIL stop_bits: %0d bad stop bits, required 0", rx_framing_err); end
        clear_streams();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_pc_repeat();
        test_overflow();
        test_trace_disable();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
